data_mem_responder: RTL and testbench

Memory-side responder for the RV32I core's data port. It accepts one load or store request at a time over a valid/ready handshake and services it against a word-organised synchronous RAM. Byte and halfword stores use an internal read-modify-write sequence; loads return the word shifted so the addressed byte or halfword sits at bit 0. Sign or zero extension is the core's job.

---
 rtl/mem_pkg.sv | 52 +++++
 rtl/word_ram.sv | 29 ++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-port responder: size codes, FSM states,
// store lane merging and access-legality checking.
package mem_pkg;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        MRG  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    // Replace byte lane off (or lanes off..off+1 for a halfword) of old_word
    // with the right-aligned low bits of wdata.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_word,
        input logic [31:0] wdata,
        input logic [1:0]  off,
        input logic        half
    );
        logic [31:0] mask;
        mask = (half ? 32'h0000_FFFF : 32'h0000_00FF) << {off, 3'b000};
        return (old_word & ~mask) | ((wdata << {off, 3'b000}) & mask);
    endfunction

    // High when the request must be answered with an error and no RAM access.
    function automatic logic addr_err(
        input logic       we,
        input logic [2:0] size,
        input logic [1:0] off
    );
        logic err;
        case (size)
            SZ_B:    err = 1'b0;
            SZ_BU:   err = we;
            SZ_H:    err = off[0];
            SZ_HU:   err = off[0] | we;
            SZ_W:    err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/word_ram.sv
// Single-port word RAM with synchronous read and write; a write takes priority
// and leaves the read register untouched.
module word_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-3:0] addr_i,
    input  logic              re_i,
    input  logic              we_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    localparam int DEPTH = 2 ** (ADDR_W - 2);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: one load/store at a time against a word RAM, with
// read-modify-write for byte/halfword stores and shifted load data.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    state_e            state_q;
    logic [ADDR_W-3:0] idx_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic [2:0]        size_q;
    logic [31:0]       wdata_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              unused_addr;

    // Upper address bits are ignored so accesses wrap within the RAM.
    assign unused_addr = ^req_addr[31:ADDR_W];

    // RAM controls are decoded from the state register only; RD and the
    // write states are disjoint, so a read and a write never coincide.
    assign ram_re    = (state_q == RD);
    assign ram_we    = (state_q == WR) || ((state_q == MRG) && we_q);
    assign ram_wdata = (state_q == WR) ? wdata_q
                     : lane_merge(ram_rdata, wdata_q, off_q, (size_q == SZ_H));

    word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .addr_i  (idx_q),
        .re_i    (ram_re),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            off_q       <= 2'b00;
            we_q        <= 1'b0;
            size_q      <= 3'b000;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        idx_q   <= req_addr[ADDR_W-1:2];
                        off_q   <= req_addr[1:0];
                        we_q    <= req_we;
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        if (addr_err(req_we, req_size, req_addr[1:0])) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else if (req_we && (req_size == SZ_W)) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    state_q <= MRG;
                end
                MRG: begin
                    if (!we_q) begin
                        rsp_rdata_q <= ram_rdata >> {off_q, 3'b000};
                    end
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                WR: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios from the
// functional description plus a randomised run against a byte-lane memory model.
module tb_data_mem_responder;

    localparam int ADDR_W = 8;
    localparam int MAX_WAIT = 20;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } op_t;

    // Scoreboard: expectations pushed when a request is driven, popped on response.
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_lat_q[$];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] obs_rd;
    logic        obs_err;
    int          obs_lat;
    logic [31:0] model [64];

    data_mem_responder #(
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_size  (req_size),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic op_t mk(input string name, input logic we, input logic [2:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rd, input logic err, input int lat);
        op_t o;
        o.name = name; o.we = we; o.size = size; o.addr = addr; o.wdata = wdata;
        o.rd = rd; o.err = err; o.lat = lat;
        return o;
    endfunction

    // Driver: present a request at a falling edge; returns once it is accepted.
    task automatic send_req(input op_t op);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = op.we;
        req_size  = op.size;
        req_addr  = op.addr;
        req_wdata = op.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_size  = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    // Monitor: count cycles from the acceptance edge until rsp_valid, capture
    // the response, and optionally complete the handshake.
    task automatic wait_rsp(input bit ack);
        obs_lat = 0;
        obs_rd  = 'x;
        obs_err = 1'bx;
        while (obs_lat < MAX_WAIT) begin
            @(negedge clk);
            obs_lat++;
            if (rsp_valid === 1'b1) break;
        end
        if (rsp_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL response_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, obs_lat);
        end else begin
            obs_rd  = rsp_rdata;
            obs_err = rsp_err;
            if (ack) begin
                rsp_ready = 1'b1;
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
            end
        end
    endtask

    task automatic run_table(input op_t ops[]);
        logic [31:0] e_rd;
        logic        e_err;
        int          e_lat;
        foreach (ops[i]) begin
            exp_q.push_back(ops[i].rd);
            exp_err_q.push_back(ops[i].err);
            exp_lat_q.push_back(ops[i].lat);
            send_req(ops[i]);
            wait_rsp(1'b1);
            e_rd  = exp_q.pop_front();
            e_err = exp_err_q.pop_front();
            e_lat = exp_lat_q.pop_front();
            checks++;
            if (obs_rd !== e_rd) begin
                errors++;
                $display("FAIL %s rdata: got %h required %h", ops[i].name, obs_rd, e_rd);
            end
            checks++;
            if (obs_err !== e_err) begin
                errors++;
                $display("FAIL %s err: got %b required %b", ops[i].name, obs_err, e_err);
            end
            checks++;
            if (obs_lat != e_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d required %0d", ops[i].name, obs_lat, e_lat);
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_we    = 1'b0;
        req_size  = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        #12;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid: got %b required 0", rsp_valid); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b required 1", req_ready); end
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset rsp_rdata: got %h required 0", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset rsp_err: got %b required 0", rsp_err); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_word();
        op_t ops[];
        ops = new[2];
        ops[0] = mk("sw_0x10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        ops[1] = mk("lw_0x10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);
        run_table(ops);
    endtask

    task automatic test_byte_merge();
        op_t ops[];
        ops = new[4];
        ops[0] = mk("sb_0x11", 1'b1, 3'b000, 32'h11, 32'hFFFFFFA5, 32'h0, 1'b0, 3);
        ops[1] = mk("lw_after_sb", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0, 3);
        ops[2] = mk("lbu_0x11", 1'b0, 3'b100, 32'h11, 32'h0, 32'h00DEADA5, 1'b0, 3);
        ops[3] = mk("lb_0x13", 1'b0, 3'b000, 32'h13, 32'h0, 32'h000000DE, 1'b0, 3);
        run_table(ops);
    endtask

    task automatic test_half_merge();
        op_t ops[];
        ops = new[5];
        ops[0] = mk("sh_0x12", 1'b1, 3'b001, 32'h12, 32'h00001234, 32'h0, 1'b0, 3);
        ops[1] = mk("lw_after_sh", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234A5EF, 1'b0, 3);
        ops[2] = mk("lhu_0x12", 1'b0, 3'b101, 32'h12, 32'h0, 32'h00001234, 1'b0, 3);
        ops[3] = mk("lhu_alias_0x112", 1'b0, 3'b101, 32'h112, 32'h0, 32'h00001234, 1'b0, 3);
        ops[4] = mk("lh_0x10_unmasked", 1'b0, 3'b001, 32'h10, 32'h0, 32'h1234A5EF, 1'b0, 3);
        run_table(ops);
    endtask

    task automatic test_errors();
        op_t ops[];
        ops = new[9];
        ops[0] = mk("lh_misaligned", 1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1, 1);
        ops[1] = mk("sw_misaligned", 1'b1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        ops[2] = mk("lw_misaligned", 1'b0, 3'b010, 32'h11, 32'h0, 32'h0, 1'b1, 1);
        ops[3] = mk("size_011", 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        ops[4] = mk("size_110", 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        ops[5] = mk("store_size_100", 1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        ops[6] = mk("store_size_101", 1'b1, 3'b101, 32'h10, 32'h0, 32'h0, 1'b1, 1);
        ops[7] = mk("sh_misaligned", 1'b1, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, 1);
        ops[8] = mk("lw_after_errors", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234A5EF, 1'b0, 3);
        run_table(ops);
    endtask

    task automatic test_backpressure();
        op_t         ld;
        logic [31:0] e_rd;
        ld = mk("bp_lw", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234A5EF, 1'b0, 3);
        exp_q.push_back(ld.rd);
        send_req(ld);
        wait_rsp(1'b0);
        e_rd = exp_q.pop_front();
        checks++;
        if (obs_rd !== e_rd) begin errors++; $display("FAIL bp_first_rdata: got %h required %h", obs_rd, e_rd); end
        // Second request waits on the bus while the response is stalled.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 3'b100;
        req_addr  = 32'h12;
        req_wdata = 32'h0;
        exp_q.push_back(32'h00001234);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cycle %0d: got %b required 1", i, rsp_valid); end
            checks++;
            if (rsp_rdata !== e_rd) begin errors++; $display("FAIL bp_hold_rdata cycle %0d: got %h required %h", i, rsp_rdata, e_rd); end
            checks++;
            if (rsp_err !== 1'b0) begin errors++; $display("FAIL bp_hold_err cycle %0d: got %b required 0", i, rsp_err); end
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_ready cycle %0d: got %b required 0", i, req_ready); end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_after_handshake_ready: got %b required 1", req_ready); end
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_after_handshake_valid: got %b required 0", rsp_valid); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wait_rsp(1'b1);
        e_rd = exp_q.pop_front();
        checks++;
        if (obs_rd !== e_rd) begin errors++; $display("FAIL bp_second_rdata: got %h required %h", obs_rd, e_rd); end
        checks++;
        if (obs_lat != 3) begin errors++; $display("FAIL bp_second_latency: got %0d required 3", obs_lat); end
    endtask

    task automatic test_reset_during_store();
        op_t ops[];
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 3'b000;
        req_addr  = 32'h10;
        req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid rsp_valid: got %b required 0", rsp_valid); end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid req_ready: got %b required 1", req_ready); end
        checks++;
        if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid rsp_rdata: got %h required 0", rsp_rdata); end
        checks++;
        if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_mid rsp_err: got %b required 0", rsp_err); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ops = new[1];
        ops[0] = mk("lw_after_reset", 1'b0, 3'b010, 32'h10, 32'h0, 32'h1234A5EF, 1'b0, 3);
        run_table(ops);
    endtask

    task automatic test_random();
        op_t         ops[];
        op_t         o;
        int          idx;
        int          off;
        logic        err;
        logic [31:0] hi;
        // Seed words 16..23 with known contents.
        ops = new[8];
        for (int i = 0; i < 8; i++) begin
            idx = 16 + i;
            hi  = $urandom & 32'hFFFF_FF00;
            o   = mk("rnd_init_sw", 1'b1, 3'b010, hi | 32'(idx << 2), $urandom, 32'h0, 1'b0, 2);
            model[idx] = o.wdata;
            ops[i] = o;
        end
        run_table(ops);
        ops = new[40];
        for (int i = 0; i < 40; i++) begin
            idx    = 16 + $urandom_range(0, 7);
            off    = $urandom_range(0, 3);
            hi     = $urandom & 32'hFFFF_FF00;
            o.name = "rnd_op";
            o.we   = 1'($urandom_range(0, 1));
            o.size = 3'($urandom_range(0, 7));
            o.addr = hi | 32'(idx << 2) | 32'(off);
            o.wdata = $urandom;
            err = 1'b0;
            if ((o.size == 3'b001 || o.size == 3'b101) && off[0]) err = 1'b1;
            if (o.size == 3'b010 && off != 0) err = 1'b1;
            if (o.size == 3'b011 || o.size == 3'b110 || o.size == 3'b111) err = 1'b1;
            if (o.we && (o.size == 3'b100 || o.size == 3'b101)) err = 1'b1;
            o.err = err;
            if (err) begin
                o.rd  = 32'h0;
                o.lat = 1;
            end else if (o.we) begin
                o.rd  = 32'h0;
                o.lat = (o.size == 3'b010) ? 2 : 3;
                case (o.size)
                    3'b000:  model[idx][8*off +: 8]  = o.wdata[7:0];
                    3'b001:  model[idx][8*off +: 16] = o.wdata[15:0];
                    default: model[idx] = o.wdata;
                endcase
            end else begin
                o.rd  = model[idx] >> (8 * off);
                o.lat = 3;
            end
            ops[i] = o;
        end
        run_table(ops);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_merge();
        test_half_merge();
        test_errors();
        test_backpressure();
        test_reset_during_store();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion before 200000");
        $fatal(1, "global timeout");
    end

endmodule
